// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: {attr,char} fetch from text RAM, glyph fetch from font ROM,
// per-pixel colour attribute with blink and underline cursor, 5-clock aligned syncs.
module text_pixel_gen #(
  parameter int COLS       = 100,
  parameter int ROWS       = 30,
  parameter int BLINK_EN   = 1,
  parameter int BLINK_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic [6:0]  cur_col_i,
  input  logic [4:0]  cur_row_i,
  input  logic        cur_en_i,
  output logic [11:0] vram_addr_o,
  input  logic [15:0] vram_data_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  output logic [7:0]  color_o,
  output logic        on_o,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o
);

  localparam int          FW    = BLINK_LOG2 + 1;
  localparam logic [10:0] X_LIM = 11'(COLS * 8);
  localparam logic [10:0] Y_LIM = 11'(ROWS * 16);

  function automatic logic glyph_bit(input logic [7:0] g, input logic [2:0] xs);
    return g[3'd7 - xs];
  endfunction

  // Blinking cells give up attr[7] as background intensity.
  function automatic logic [7:0] attr_color(input logic [7:0] a, input logic blink);
    return blink ? {1'b0, a[6:0]} : a;
  endfunction

  logic [6:0]    col_c;
  logic [5:0]    row_c;
  logic [11:0]   addr_c;
  logic          area_c;
  logic          cur_c;

  logic          vs_q;
  logic [FW-1:0] fcnt;

  logic [2:0]    xsub_p1, xsub_p2, xsub_p3, xsub_p4;
  logic [3:0]    yrow_p1, yrow_p2, yrow_p3, yrow_p4;
  logic          vld_p1, vld_p2, vld_p3, vld_p4;
  logic          hs_p1, hs_p2, hs_p3, hs_p4;
  logic          vs_p1, vs_p2, vs_p3, vs_p4;
  logic          area_p1, area_p2, area_p3, area_p4;
  logic          cur_p1, cur_p2, cur_p3, cur_p4;
  logic [7:0]    attr_p3, attr_p4;

  logic          px;
  logic          blink;
  logic          bphase;
  logic          cphase;
  logic          cur_on;
  logic [7:0]    color_n;
  logic          on_n;

  assign col_c  = x_i[9:3];
  assign row_c  = y_i[9:4];
  assign addr_c = 12'(row_c) * 12'(COLS) + 12'(col_c);
  assign area_c = ({1'b0, x_i} < X_LIM) && ({1'b0, y_i} < Y_LIM);
  assign cur_c  = cur_en_i && (col_c == cur_col_i) && (row_c == {1'b0, cur_row_i});

  // Frame counter advances on each vsync rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q <= 1'b0;
      fcnt <= '0;
    end else begin
      vs_q <= vs_i;
      if (vs_i && !vs_q)
        fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vram_addr_o <= '0;
      font_addr_o <= '0;
      xsub_p1 <= '0; yrow_p1 <= '0; vld_p1 <= 1'b0; hs_p1 <= 1'b0;
      vs_p1 <= 1'b0; area_p1 <= 1'b0; cur_p1 <= 1'b0;
      xsub_p2 <= '0; yrow_p2 <= '0; vld_p2 <= 1'b0; hs_p2 <= 1'b0;
      vs_p2 <= 1'b0; area_p2 <= 1'b0; cur_p2 <= 1'b0;
      xsub_p3 <= '0; yrow_p3 <= '0; vld_p3 <= 1'b0; hs_p3 <= 1'b0;
      vs_p3 <= 1'b0; area_p3 <= 1'b0; cur_p3 <= 1'b0; attr_p3 <= '0;
      xsub_p4 <= '0; yrow_p4 <= '0; vld_p4 <= 1'b0; hs_p4 <= 1'b0;
      vs_p4 <= 1'b0; area_p4 <= 1'b0; cur_p4 <= 1'b0; attr_p4 <= '0;
      color_o <= '0;
      on_o    <= 1'b0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
    end else begin
      // E1: text RAM address and coordinate capture
      vram_addr_o <= addr_c;
      xsub_p1 <= x_i[2:0]; yrow_p1 <= y_i[3:0]; vld_p1 <= de_i; hs_p1 <= hs_i;
      vs_p1 <= vs_i; area_p1 <= area_c; cur_p1 <= cur_c;
      // E2: RAM read in flight
      xsub_p2 <= xsub_p1; yrow_p2 <= yrow_p1; vld_p2 <= vld_p1; hs_p2 <= hs_p1;
      vs_p2 <= vs_p1; area_p2 <= area_p1; cur_p2 <= cur_p1;
      // E3: font address from the fetched character, attribute latched
      font_addr_o <= {vram_data_i[7:0], yrow_p2};
      attr_p3 <= vram_data_i[15:8];
      xsub_p3 <= xsub_p2; yrow_p3 <= yrow_p2; vld_p3 <= vld_p2; hs_p3 <= hs_p2;
      vs_p3 <= vs_p2; area_p3 <= area_p2; cur_p3 <= cur_p2;
      // E4: ROM read in flight
      attr_p4 <= attr_p3;
      xsub_p4 <= xsub_p3; yrow_p4 <= yrow_p3; vld_p4 <= vld_p3; hs_p4 <= hs_p3;
      vs_p4 <= vs_p3; area_p4 <= area_p3; cur_p4 <= cur_p3;
      // E5: output register
      color_o <= color_n;
      on_o    <= on_n;
      de_o    <= vld_p4;
      hs_o    <= hs_p4;
      vs_o    <= vs_p4;
    end
  end

  always_comb begin
    bphase  = fcnt[BLINK_LOG2];
    cphase  = fcnt[BLINK_LOG2-1];
    px      = glyph_bit(font_data_i, xsub_p4);
    blink   = (BLINK_EN != 0) && attr_p4[7];
    cur_on  = cur_p4 && (yrow_p4[3:1] == 3'b111) && cphase;
    color_n = attr_color(attr_p4, blink);
    on_n    = (blink ? (px & ~bphase) : px) | cur_on;
    if (!(vld_p4 && area_p4)) begin
      color_n = '0;
      on_n    = 1'b0;
    end
  end

endmodule
